uart_tx: RTL and testbench

UART serial transmitter: accepts one 8-bit parallel byte on a start request and shifts it out LSB-first on `uart_txd` as an 8N1 frame (start bit, 8 data bits, stop bit) at a fixed baud rate derived from the system clock. It is the transmit counterpart of the `uart_rx` block. Together they form the board's serial link: `uart_rx` output feeds loopback and command logic, and `uart_tx` returns bytes to the host.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_tx_if.sv | 23 ++
 rtl/uart_baud_gen.sv | 43 ++++
 rtl/uart_tx.sv | 154 +++++++++++++++
 tb/tb_uart_tx.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by uart_tx and uart_rx: frame constants,
// default clocking, FSM state type and the parity helper.
// Optional build macro: UART_TX_PARITY_EN adds an even-parity bit (8E1).
package uart_pkg;

    localparam int DATA_BITS         = 8;
    localparam int BIT_IDX_W         = $clog2(DATA_BITS);
    localparam int DEFAULT_CLK_FREQ  = 50_000_000;
    localparam int DEFAULT_BAUD_RATE = 115200;

    // PARITY only exists in the parity-enabled build.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_state_e;

    // Even parity: total count of ones over data plus parity bit is even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-in / serial-out handshake bundle of the UART transmitter.
// Optional build macro: UART_TX_PARITY_EN (no effect on this interface).
interface uart_tx_if;
    import uart_pkg::*;

    logic                 uart_en;
    logic [DATA_BITS-1:0] uart_data_in;
    logic                 uart_txd;
    logic                 uart_busy;
    logic                 uart_tx_done;

    // Byte producer side (host logic or testbench).
    modport master (
        output uart_en, uart_data_in,
        input  uart_txd, uart_busy, uart_tx_done
    );

    // Transmitter side.
    modport slave (
        input  uart_en, uart_data_in,
        output uart_txd, uart_busy, uart_tx_done
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..BAUD_CNT-1 and flags the last clock of each
// bit period. A clear pulse realigns the count to the accepted frame.
// Optional build macro: UART_TX_PARITY_EN (no effect on this block).
module uart_baud_gen #(
    parameter int BAUD_CNT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick
);

    localparam int CNT_W = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Tick during the final clock of a bit so the FSM moves on the boundary edge.
    assign bit_tick = (cnt_q == CNT_LAST) && !clear;

    // Next count: restart on clear, wrap at the end of each bit period.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a byte in IDLE and sends it LSB first as an
// 8N1 frame (start, 8 data, stop) with every output registered.
// Optional build macro: UART_TX_PARITY_EN inserts an even-parity bit (8E1).
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE = DEFAULT_BAUD_RATE
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  bus
);

    localparam int BAUD_CNT = CLK_FREQ / BAUD_RATE;
    localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic                 txd_q, txd_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif
    logic                 bit_tick_s;
    logic                 clear_s;

    // Restart the bit timer on the accepting edge so the start bit is full length.
    assign clear_s = (state_q == ST_IDLE) && bus.uart_en;

    uart_baud_gen #(.BAUD_CNT(BAUD_CNT)) u_baud_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear_s),
        .bit_tick (bit_tick_s)
    );

    assign bus.uart_txd     = txd_q;
    assign bus.uart_busy    = busy_q;
    assign bus.uart_tx_done = done_q;

    // Next-state logic: each non-idle state holds its line level for one bit period.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        txd_d     = txd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (bus.uart_en) begin
                    shift_d   = bus.uart_data_in;
                    bit_idx_d = '0;
                    busy_d    = 1'b1;
                    txd_d     = 1'b0;
                    state_d   = ST_START;
`ifdef UART_TX_PARITY_EN
                    parity_d  = even_parity(bus.uart_data_in);
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_tick_s) begin
                    txd_d     = shift_q[0];
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_tick_s) begin
                    if (bit_idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        txd_d   = parity_q;
                        state_d = ST_PARITY;
`else
                        txd_d   = 1'b1;
                        state_d = ST_STOP;
`endif
                    end else begin
                        // Shift first so the next bit is always at index 1 of the old value.
                        shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
                        txd_d     = shift_q[1];
                        bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_tick_s) begin
                    txd_d   = 1'b1;
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (bit_tick_s) begin
                    txd_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                txd_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and output registers; reset abandons any frame and idles the line high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: reset, table of known frames, busy-ignore,
// back-to-back, reset mid-frame and random bytes against a frame model.
// Honours UART_TX_PARITY_EN for the 8E1 build.
module tb_uart_tx;

    localparam int B = 434;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * B;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // bit i = i-th line bit of the 8N1 frame
        logic       par;     // expected even-parity bit
        string      name;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    uart_tx_if bus_if ();

    uart_tx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #(950_000);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference frame built from the framing rules.
    function automatic logic [NBITS-1:0] model_frame(input logic [7:0] d);
        bit q[$];
        logic [NBITS-1:0] r;
        int ones;
        ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            q.push_back(d[i]);
            ones += int'(d[i]);
        end
`ifdef UART_TX_PARITY_EN
        q.push_back((ones % 2) == 1);
`endif
        q.push_back(1'b1);
        for (int k = 0; k < NBITS; k++) r[k] = q[k];
        return r;
    endfunction

    function automatic logic [NBITS-1:0] table_frame(input logic [9:0] f, input logic p);
        logic [NBITS-1:0] r;
`ifdef UART_TX_PARITY_EN
        r = {f[9], p, f[8:0]};
`else
        r = f;
        r[0] = r[0] | (p & 1'b0);
`endif
        return r;
    endfunction

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus_if.uart_busy !== 1'b0 && n < 10000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, " idle wait"}, 32'(n < 10000), 32'd1);
    endtask

    // Drive a one-cycle request; returns #1 after the accepting edge.
    task automatic accept(input logic [7:0] d);
        @(negedge clk);
        bus_if.uart_en      = 1'b1;
        bus_if.uart_data_in = d;
        @(posedge clk); #1;
        bus_if.uart_en      = 1'b0;
        bus_if.uart_data_in = 8'($urandom);
    endtask

    // Entered #1 after the accepting edge; checks every clock of the frame.
    task automatic check_frame(input logic [NBITS-1:0] exp, input string name,
                               input int inj_at, input int rst_at);
        int mism [NBITS];
        logic [NBITS-1:0] mid;
        int busy_bad, done_bad, stop_c, nchk;
        bit aborted;
        for (int k = 0; k < NBITS; k++) mism[k] = 0;
        mid = '0; busy_bad = 0; done_bad = 0; aborted = 1'b0; stop_c = FRAME;
        for (int c = 0; c < FRAME; c++) begin
            int k;
            if (c > 0) begin @(posedge clk); #1; end
            k = c / B;
            if (bus_if.uart_txd !== exp[k]) mism[k]++;
            if (c == k * B + B / 2) mid[k] = bus_if.uart_txd;
            if (bus_if.uart_busy !== 1'b1) busy_bad++;
            if (bus_if.uart_tx_done !== 1'b0) done_bad++;
            if (inj_at >= 0 && c == inj_at) begin
                bus_if.uart_en = 1'b1; bus_if.uart_data_in = 8'h55;
            end
            if (inj_at >= 0 && c == inj_at + 1) begin
                bus_if.uart_en = 1'b0; bus_if.uart_data_in = 8'($urandom);
            end
            if (c == rst_at) begin
                aborted = 1'b1; stop_c = c;
                break;
            end
        end
        if (aborted) begin
            rst = 1'b1;
            @(posedge clk); #1;
            chk({name, " abort txd"},  32'(bus_if.uart_txd),     32'd1);
            chk({name, " abort busy"}, 32'(bus_if.uart_busy),    32'd0);
            chk({name, " abort done"}, 32'(bus_if.uart_tx_done), 32'd0);
            rst = 1'b0;
            nchk = stop_c / B;
        end else begin
            @(posedge clk); #1;
            chk({name, " done pulse"}, 32'(bus_if.uart_tx_done), 32'd1);
            chk({name, " busy clear"}, 32'(bus_if.uart_busy),    32'd0);
            chk({name, " idle txd"},   32'(bus_if.uart_txd),     32'd1);
            nchk = NBITS;
        end
        for (int k = 0; k < nchk; k++) begin
            chk($sformatf("%s bit%0d mid", name, k), 32'(mid[k]), 32'(exp[k]));
            chk($sformatf("%s bit%0d bad clocks", name, k), 32'(mism[k]), 32'd0);
        end
        chk({name, " busy low clocks"}, 32'(busy_bad), 32'd0);
        chk({name, " early done clocks"}, 32'(done_bad), 32'd0);
    endtask

    task automatic idle_watch(input int n, input string name);
        int t, b, d;
        t = 0; b = 0; d = 0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            if (bus_if.uart_txd !== 1'b1) t++;
            if (bus_if.uart_busy !== 1'b0) b++;
            if (bus_if.uart_tx_done !== 1'b0) d++;
        end
        chk({name, " idle txd clocks"},  32'(t), 32'd0);
        chk({name, " idle busy clocks"}, 32'(b), 32'd0);
        chk({name, " idle done clocks"}, 32'(d), 32'd0);
    endtask

    initial begin
        vec_t tbl [5];
        logic [7:0] rd;
        tbl[0] = '{8'hC9, 10'b11_1001_0010, 1'b0, "c9"};
        tbl[1] = '{8'hC8, 10'b11_1001_0000, 1'b1, "c8"};
        tbl[2] = '{8'hA5, 10'b11_0100_1010, 1'b0, "a5"};
        tbl[3] = '{8'h3C, 10'b10_0111_1000, 1'b0, "3c"};
        tbl[4] = '{8'h01, 10'b10_0000_0010, 1'b1, "01"};

        // Reset held 5 cycles with a competing start request.
        rst = 1'b1;
        bus_if.uart_en      = 1'b1;
        bus_if.uart_data_in = 8'hC9;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("reset txd c%0d", i),  32'(bus_if.uart_txd),     32'd1);
            chk($sformatf("reset busy c%0d", i), 32'(bus_if.uart_busy),    32'd0);
            chk($sformatf("reset done c%0d", i), 32'(bus_if.uart_tx_done), 32'd0);
        end
        bus_if.uart_en = 1'b0;
        rst = 1'b0;
        idle_watch(3, "post reset");

        // Known frames.
        for (int i = 0; i < 5; i++) begin
            wait_idle(tbl[i].name);
            accept(tbl[i].data);
            check_frame(table_frame(tbl[i].frame, tbl[i].par), tbl[i].name, -1, -1);
            idle_watch(2, tbl[i].name);
        end

        // Request while busy is dropped, not queued.
        wait_idle("busy ign");
        accept(8'hC9);
        check_frame(table_frame(10'b11_1001_0010, 1'b0), "busy ign", 1000, -1);
        idle_watch(600, "busy ign");

        // Back-to-back with the request held high.
        @(negedge clk);
        bus_if.uart_en      = 1'b1;
        bus_if.uart_data_in = 8'h00;
        @(posedge clk); #1;
        bus_if.uart_data_in = 8'hFF;
        check_frame(table_frame(10'b10_0000_0000, 1'b0), "b2b first", -1, -1);
        @(posedge clk); #1;
        bus_if.uart_en      = 1'b0;
        bus_if.uart_data_in = 8'($urandom);
        check_frame(table_frame(10'b11_1111_1110, 1'b0), "b2b second", -1, -1);
        idle_watch(2, "b2b");

        // Reset during data bit 4 of 0xA5, then a clean 0x3C.
        accept(8'hA5);
        check_frame(table_frame(10'b11_0100_1010, 1'b0), "rst mid", -1, 5 * B + B / 2);
        idle_watch(2 * B, "rst mid");
        accept(8'h3C);
        check_frame(table_frame(10'b10_0111_1000, 1'b0), "after rst", -1, -1);

        // Random bytes against the frame model.
        for (int i = 0; i < 3; i++) begin
            rd = 8'($urandom_range(0, 255));
            repeat ($urandom_range(1, 5)) @(posedge clk);
            #1;
            wait_idle("rand");
            accept(rd);
            check_frame(model_frame(rd), $sformatf("rand %02h", rd), -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
